// File: rtl/thread_generator.sv
// Raster-order pixel dispatcher. Issues one (x, y) coordinate per clock while the ray core
// reports free, walking the frame left-to-right, top-to-bottom.
// Optional feature macro: THREADGEN_FRAME_LOOP_EN -- when defined, the frame restarts from
// (0,0) after a one-cycle WRAP_WAIT gap instead of parking in DONE until reset.
module thread_generator #(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ray_core_free,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       valid
);

  localparam logic [9:0] XMax = 10'(H_RES - 1);
  localparam logic [9:0] YMax = 10'(V_RES - 1);

`ifdef THREADGEN_FRAME_LOOP_EN
  typedef enum logic [1:0] {StIssue = 2'd0, StDone = 2'd1, StWrapWait = 2'd2} state_e;
`else
  typedef enum logic [1:0] {StIssue = 2'd0, StDone = 2'd1} state_e;
`endif

  state_e     state_q, state_d;
  logic [9:0] cx_q, cx_d;
  logic [9:0] cy_q, cy_d;
  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic       valid_q, valid_d;
  logic [1:0] sync_q;
  logic       rst_n;

  // Reset synchronizer: assertion passes straight through, release takes two clk edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_n = sync_q[1];

  // State, cursor and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIssue;
      cx_q      <= '0;
      cy_q      <= '0;
      pixel_x_q <= '0;
      pixel_y_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      pixel_x_q <= pixel_x_d;
      pixel_y_q <= pixel_y_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state: issue the cursor pixel when the core is free, then advance in raster order.
  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    pixel_x_d = pixel_x_q;
    pixel_y_d = pixel_y_q;
    valid_d   = 1'b0;
    unique case (state_q)
      StIssue: begin
        if (ray_core_free) begin
          pixel_x_d = cx_q;
          pixel_y_d = cy_q;
          valid_d   = 1'b1;
          if (cx_q == XMax) begin
            cx_d = '0;
            if (cy_q == YMax) begin
              cy_d = '0;
`ifdef THREADGEN_FRAME_LOOP_EN
              state_d = StWrapWait;
`else
              state_d = StDone;
`endif
            end else begin
              cy_d = cy_q + 10'd1;
            end
          end else begin
            cx_d = cx_q + 10'd1;
          end
        end
      end
      // Frame finished: outputs hold, core requests ignored until reset.
      StDone: begin
        state_d = StDone;
      end
`ifdef THREADGEN_FRAME_LOOP_EN
      // One idle cycle between frames; the cursor is already back at (0,0).
      StWrapWait: begin
        state_d = StIssue;
      end
`endif
      default: begin
        state_d = StIssue;
      end
    endcase
  end

  assign pixel_x = pixel_x_q;
  assign pixel_y = pixel_y_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_thread_generator.sv
// Bench for thread_generator: a default-size instance (a) and a 4x3 instance (b) share clock
// and reset. A cursor model pushes expected pixels to per-instance queues as stimulus is
// driven; each sample pops and compares against the DUT outputs.
module tb_thread_generator;

`ifdef THREADGEN_FRAME_LOOP_EN
  localparam bit Loop = 1'b1;
`else
  localparam bit Loop = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       free_a, free_b;
  logic [9:0] pixel_x_a, pixel_y_a, pixel_x_b, pixel_y_b;
  logic       valid_a, valid_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [19:0] q_a[$];
  logic [19:0] q_b[$];

  int hres[2] = '{640, 4};
  int vres[2] = '{480, 3};
  int mx[2], my[2], lx[2], ly[2], cnt[2];
  bit done[2], wt[2], pushed[2];

  thread_generator dut_a (
    .clk          (clk),
    .rst          (rst),
    .ray_core_free(free_a),
    .pixel_x      (pixel_x_a),
    .pixel_y      (pixel_y_a),
    .valid        (valid_a)
  );

  thread_generator #(
    .H_RES(4),
    .V_RES(3)
  ) dut_b (
    .clk          (clk),
    .rst          (rst),
    .ray_core_free(free_b),
    .pixel_x      (pixel_x_b),
    .pixel_y      (pixel_y_b),
    .valid        (valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset(input int i);
    mx[i] = 0; my[i] = 0; lx[i] = 0; ly[i] = 0;
    cnt[i] = 2; done[i] = 1'b0; wt[i] = 1'b0; pushed[i] = 1'b0;
    if (i == 0) q_a.delete(); else q_b.delete();
  endtask

  // Predict what one clock edge does to instance i given its free input.
  task automatic model_edge(input int i, input bit f);
    logic [19:0] e;
    pushed[i] = 1'b0;
    if (!rst) begin
      model_reset(i);
    end else if (cnt[i] > 0) begin
      cnt[i]--;
    end else if (wt[i]) begin
      wt[i] = 1'b0;
    end else if (!done[i] && f) begin
      e = {10'(my[i]), 10'(mx[i])};
      if (i == 0) q_a.push_back(e); else q_b.push_back(e);
      pushed[i] = 1'b1;
      lx[i] = mx[i];
      ly[i] = my[i];
      if (mx[i] == hres[i] - 1) begin
        mx[i] = 0;
        if (my[i] == vres[i] - 1) begin
          my[i] = 0;
          if (Loop) wt[i] = 1'b1; else done[i] = 1'b1;
        end else begin
          my[i]++;
        end
      end else begin
        mx[i]++;
      end
    end
  endtask

  task automatic check(input int i, input logic v, input logic [9:0] px, input logic [9:0] py);
    logic [19:0] exp;
    string       tag;
    tag = (i == 0) ? "a" : "b";
    exp = {10'(ly[i]), 10'(lx[i])};
    if (pushed[i]) begin
      if (i == 0) exp = q_a.pop_front(); else exp = q_b.pop_front();
    end
    n_tests++;
    assert (v === pushed[i]) else begin
      n_fail++;
      $error("FAIL %s_valid got %0b expected %0b", tag, v, pushed[i]);
    end
    n_tests++;
    assert ({py, px} === exp) else begin
      n_fail++;
      $error("FAIL %s_pixel got (%0d,%0d) expected (%0d,%0d)", tag, px, py, exp[9:0],
             exp[19:10]);
    end
  endtask

  task automatic check_all();
    check(0, valid_a, pixel_x_a, pixel_y_a);
    check(1, valid_b, pixel_x_b, pixel_y_b);
  endtask

  // Drive inputs at a falling edge, let one rising edge pass, sample at the next falling edge.
  task automatic step(input bit fa, input bit fb);
    free_a = fa;
    free_b = fb;
    model_edge(0, fa);
    model_edge(1, fb);
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset assertion: outputs must clear without any clock edge.
  task automatic async_reset_check();
    #1;
    rst = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    check_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b0;
    free_a = 1'b0;
    free_b = 1'b0;
    model_reset(0);
    model_reset(1);

    // Reset held for 5 cycles: everything zero.
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0);

    // Release with the core busy: no pixels for 10 cycles.
    rst = 1'b1;
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0);

    // Stalls on the default-size instance: 5 free, 5 busy (pixel_x holds 4), 3 free.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0);

    // Full 4x3 frame back-to-back, then keep the core free past the frame end.
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1);

    // Fresh reset, then run the 4x3 instance up to pixel (2,1).
    async_reset_check();
    step(1'b0, 1'b0);
    rst = 1'b1;
    for (int k = 0; k < 9; k++) step(1'b0, 1'b1);

    // Mid-frame reset right after (2,1); restart must begin at (0,0).
    async_reset_check();
    step(1'b0, 1'b1);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1);

    n_tests++;
    assert (q_a.size() + q_b.size() === 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain got %0d left expected 0", q_a.size() + q_b.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
